// File: rtl/grid_mem_responder.sv
// grid_mem_responder: word memory responder with sweep-clear engine; define GRID_MEM_CLEAR_ON_RESET_EN to auto-clear after reset
module grid_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic clear_busy_q, clear_done_q;
  logic sweeping, last, in_range, start;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef GRID_MEM_CLEAR_ON_RESET_EN
  logic init_q;
  // Holds a pending automatic clear from reset until the first clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) init_q <= 1'b1;
    else init_q <= 1'b0;
  assign start = clear_start | init_q;
`else
  assign start = clear_start;
`endif
  // Next-state, sweep address and read-first data selection
  always_comb begin
    sweeping = state_q == SWEEP;
    last = clear_addr_q == ADDR_WIDTH'(DEPTH - 1);
    in_range = int'(addr) < DEPTH;
    state_d = (state_q == IDLE && start) ? SWEEP : (sweeping && !last) ? SWEEP : sweeping ? DONE : IDLE;
    clear_addr_d = sweeping ? clear_addr_q + ADDR_WIDTH'(1) : '0;
    r_data_d = (sweeping || !in_range) ? '0 : mem[addr];
  end
  // Clear FSM with registered read data and status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      clear_addr_q <= '0;
      r_data_q <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_addr_q <= clear_addr_d;
      r_data_q <= r_data_d;
      clear_busy_q <= state_d == SWEEP;
      clear_done_q <= state_d == DONE;
    end
  // Single write port: the sweep owns it while clearing, client writes are dropped
  always_ff @(posedge clk)
    if (sweeping) mem[clear_addr_q] <= '0;
    else if (we && in_range) mem[addr] <= w_data;
  assign r_data = r_data_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
endmodule

// File: tb/tb_grid_mem_responder.sv
// tb_grid_mem_responder: directed and random checks of grid_mem_responder against a word-array model
module tb_grid_mem_responder;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0;
  logic clear_start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic clear_busy, clear_done;
  int n_assert = 0;
  int n_fail = 0;
  logic [DW-1:0] model [D];
  bit known [D];
  int sweep_left = 0;
  bit exp_done = 1'b0;
  bit auto_pend = 1'b0;

  grid_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .w_data(w_data),
    .r_data(r_data), .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit sw, idle, in_r, ek;
    logic [DW-1:0] er;
    sw = sweep_left > 0;
    idle = !sw && !exp_done;
    in_r = int'(addr) < D;
    er = (sw || !in_r) ? '0 : model[addr[3:0]];
    ek = sw || !in_r || known[addr[3:0]];
    if (!sw && we && in_r) begin
      model[addr[3:0]] = w_data;
      known[addr[3:0]] = 1'b1;
    end
    if (sw) begin
      sweep_left--;
      exp_done = sweep_left == 0;
    end else begin
      exp_done = 1'b0;
      if (idle && (clear_start || auto_pend)) begin
        sweep_left = D;
        for (int i = 0; i < D; i++) begin
          model[i] = '0;
          known[i] = 1'b1;
        end
      end
    end
    auto_pend = 1'b0;
    @(posedge clk);
    #1;
    if (ek) check("r_data", r_data, er);
    check("clear_busy", DW'(clear_busy), DW'(sweep_left > 0));
    check("clear_done", DW'(clear_done), DW'(exp_done));
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    addr = AW'(a);
    we = 1'b1;
    w_data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int a);
    addr = AW'(a);
    we = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_r_data", r_data, '0);
    check("rst_busy", DW'(clear_busy), '0);
    check("rst_done", DW'(clear_done), '0);
    sweep_left = 0;
    exp_done = 1'b0;
    for (int i = 0; i < D; i++) known[i] = 1'b0;
    #2;
    rst_n = 1'b1;
`ifdef GRID_MEM_CLEAR_ON_RESET_EN
    auto_pend = 1'b1;
`endif
  endtask

  task automatic settle_after_reset();
`ifdef GRID_MEM_CLEAR_ON_RESET_EN
    int bc, dc;
    bc = 0;
    dc = 0;
    repeat (D + 3) begin
      tick();
      bc += int'(clear_busy);
      dc += int'(clear_done);
    end
    check("auto_busy_cycles", DW'(bc), DW'(D));
    check("auto_done_pulses", DW'(dc), 32'd1);
`else
    repeat (3) tick();
`endif
  endtask

  initial begin
    int bc, dc;
    #3;
    do_reset();
    settle_after_reset();
    for (int i = 0; i < D; i++) wr(i, 32'hFFFF_FFFF);
    clear_start = 1'b1;
    bc = 0;
    dc = 0;
    for (int i = 0; i < D + 3; i++) begin
      tick();
      clear_start = 1'b0;
      bc += int'(clear_busy);
      dc += int'(clear_done);
    end
    check("sweep_busy_cycles", DW'(bc), DW'(D));
    check("sweep_done_pulses", DW'(dc), 32'd1);
    for (int i = 0; i < D; i++) begin
      rd(i);
      check("cleared_word", r_data, '0);
    end
    wr(5, 32'hDEAD_BEEF);
    rd(5);
    check("wr_rd_5", r_data, 32'hDEAD_BEEF);
    wr(7, 32'h1);
    wr(7, 32'h2);
    check("collision_old", r_data, 32'h1);
    rd(7);
    check("collision_new", r_data, 32'h2);
    addr = AW'(2);
    tick();
    w_data = r_data | (32'h1 << 3);
    we = 1'b1;
    tick();
    we = 1'b0;
    rd(2);
    check("rmw_word2", r_data, 32'h8);
    wr(20, 32'hAA);
    rd(20);
    check("oor_read", r_data, '0);
    rd(4);
    check("oor_no_alias", r_data, '0);
    bc = 0;
    dc = 0;
    for (int i = 0; i < D + 3; i++) begin
      clear_start = (i == 0 || i == 8);
      we = (i == 3);
      addr = AW'(3);
      w_data = 32'hAA;
      tick();
      if (i == 3) check("sweep_r_data", r_data, '0);
      bc += int'(clear_busy);
      dc += int'(clear_done);
    end
    clear_start = 1'b0;
    we = 1'b0;
    check("restart_busy_cycles", DW'(bc), DW'(D));
    check("restart_done_pulses", DW'(dc), 32'd1);
    rd(3);
    check("sweep_drop_write", r_data, '0);
    for (int n = 0; n < 300; n++) begin
      addr = AW'($urandom_range(0, 2 * D - 1));
      we = 1'($urandom_range(0, 1));
      w_data = $urandom;
      clear_start = $urandom_range(0, 39) == 0;
      tick();
    end
    clear_start = 1'b0;
    we = 1'b0;
    repeat (D + 2) tick();
    wr(9, 32'h1234_5678);
    addr = AW'(9);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", DW'(clear_busy), 32'd1);
    do_reset();
    settle_after_reset();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (D + 1) tick();
    for (int n = 0; n < 100; n++) begin
      addr = AW'($urandom_range(0, 2 * D - 1));
      we = 1'($urandom_range(0, 1));
      w_data = $urandom;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_mem_responder.md
Name: grid_mem_responder

Overview:
- Memory-bus responder (server end) answering the grid client's word reads and read-modify-write write-backs.
- Backed by a synchronous single-port word array with a fixed one-cycle registered read latency; the client's fixed-latency sequencing depends on this timing.
- Includes a sweep-clear engine that zeroes the whole array on request, so a new planning run starts from an empty occupancy grid.

Parameters:
ADDR_WIDTH, 10, word address width; matches the bus ADDR_WIDTH.
DATA_WIDTH, 32, word width in bits; matches the bus DATA_WIDTH.
DEPTH, 2**ADDR_WIDTH, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  input  1  sole clock; the instantiating level connects this same net to mem.clk.
rst_n  input  1  reset, asynchronous, active-low.
addr  input  ADDR_WIDTH  word address from client (bus addr).
we  input  1  write enable from client (bus we).
w_data  input  DATA_WIDTH  write data from client (bus w_data).
r_data  output  DATA_WIDTH  registered read data to client (bus r_data).
clear_start  input  1  single-cycle request to zero the array.
clear_busy  output  1  high while a sweep is in progress.
clear_done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (async assert, synchronous deassert is provided externally): r_data=0, clear_busy=0, clear_done=0, FSM=IDLE, clear_addr=0. Array contents are not reset.
- Read: at each rising edge, r_data <= array[addr]. The value is visible in the cycle after addr was sampled (latency 1).
- Write: at a rising edge with we=1, array[addr] <= w_data.
- Read-during-write to the same address is read-first: r_data gets the old word, and the new word is readable from the next edge on.
- Out of range (addr >= DEPTH): writes are dropped and reads return 0.
- The responder never stalls the client; there is no ready signal.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clear_start=1 -> SWEEP, clear_addr=0. Any client access in the same cycle still executes normally.
  - SWEEP: each cycle array[clear_addr] <= 0 and clear_addr increments. The write at clear_addr = DEPTH-1 -> DONE.
  - SWEEP lasts exactly DEPTH cycles; clear_busy=1 for exactly those cycles.
  - DONE: clear_done=1 for one cycle, then -> IDLE.
  - clear_start is ignored in SWEEP and DONE; it is not queued.
- Client access during SWEEP: we is ignored (write dropped) and r_data <= 0. The client must wait for clear_done before relying on data.
- Client access in DONE: serviced normally.
- clear_addr width is ADDR_WIDTH. The terminal compare is against DEPTH-1, so no wrap occurs even when DEPTH = 2**ADDR_WIDTH.
- Reset asserted mid-sweep: the sweep aborts immediately and outputs return to reset values. Partially cleared contents are left as-is, except as described under the optional feature.

Optional Feature:
- Macro: GRID_MEM_CLEAR_ON_RESET_EN.
- Defined: on the first clock after rst_n deasserts, the FSM enters SWEEP automatically, with clear_busy/clear_done behaving exactly as for a clear_start request. This also covers a sweep that was aborted by reset.
- clear_start arriving during this automatic sweep is ignored.
- Undefined: the FSM stays in IDLE after reset, and array contents are undefined until the first clear_start sweep completes.

Test Plan:
- Write then read: we=1, addr=5, w_data=0xDEADBEEF; next cycle we=0, addr=5 -> r_data=0xDEADBEEF one cycle later.
- Read-first collision: array[7]=0x1, then we=1, addr=7, w_data=0x2 -> r_data=0x1 after that edge; a read of addr=7 on the next cycle -> 0x2.
- Client RMW emulation: issue the grid client's sequence (set address, wait one cycle, write back r_data|(1<<3)) on word 2, starting from 0 -> word 2 reads 0x8.
- Clear sweep with DEPTH=16: fill all words with 0xFFFFFFFF, pulse clear_start -> clear_busy high for exactly 16 cycles, then clear_done pulses for 1 cycle; all 16 words read 0.
- Access during sweep: we=1, addr=3, w_data=0xAA while clear_busy=1 -> r_data=0 during the sweep; word 3 reads 0 afterwards. A second clear_start mid-sweep does not extend clear_busy.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 6 -> clear_busy=0 and r_data=0 immediately. With GRID_MEM_CLEAR_ON_RESET_EN, a full 16-cycle sweep follows deassertion and clear_done pulses once.
